// File: rtl/axis_packet_reducer.sv
// Sums the beats of each tlast-delimited packet (signed) and emits one result word per packet.
// Optional AXIS_PACKET_REDUCER_SATURATE_EN: sticky signed saturation of the accumulator.
module axis_packet_reducer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int PCKT_WIDTH  = 32,
  parameter int ALLOW_LOCKS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  operation_start,
  input  logic [PCKT_WIDTH-1:0] packet_count,
  input  logic                  lock,
  input  logic                  external_error,
  output logic                  operation_busy,
  output logic                  operation_complete,
  output logic                  operation_error,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [ACC_WIDTH-1:0]  m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d, m_data_q, m_data_d, sum, samp_ext;
  logic [PCKT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d, cnt_q, cnt_d;
  logic                   m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic                   busy_q, busy_d, cmpl_q, cmpl_d, err_q, err_d;
  logic                   lock_eff, all_pkts, accept, out_hs, start_go;

  assign lock_eff  = (ALLOW_LOCKS != 0) && lock;
  assign all_pkts  = (pkt_cnt_q == cnt_q);
  assign out_hs    = m_valid_q && m_axis_tready;
  // Once every packet's tlast is in, the input closes even while the last word drains.
  assign s_axis_tready = (state_q == S_RUN) && !lock_eff && !all_pkts && (!m_valid_q || m_axis_tready);
  assign accept    = s_axis_tvalid && s_axis_tready;
  assign samp_ext  = ACC_WIDTH'($signed(s_axis_tdata));

`ifdef AXIS_PACKET_REDUCER_SATURATE_EN
  logic                 sat_q, sat_d, ovf;
  logic [ACC_WIDTH:0]   sum_w;
  assign sum_w = {acc_q[ACC_WIDTH-1], acc_q} + {samp_ext[ACC_WIDTH-1], samp_ext};
  assign ovf   = sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1];
  always_comb begin
    sum = sum_w[ACC_WIDTH-1:0];
    if (sat_q)    sum = acc_q;
    else if (ovf) sum = sum_w[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end
`else
  assign sum = acc_q + samp_ext;
`endif

  always_comb begin
    state_d = state_q;
    if (external_error) begin
      state_d = S_ERR;
    end else if (!lock_eff) begin
      case (state_q)
        S_IDLE, S_DONE: if (operation_start) state_d = (packet_count == '0) ? S_ERR : S_RUN;
        S_RUN:          if (all_pkts && (!m_valid_q || out_hs)) state_d = S_DONE;
        S_ERR:          state_d = S_IDLE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  assign start_go = (state_q == S_IDLE || state_q == S_DONE) && (state_d == S_RUN);

  always_comb begin
    acc_d     = acc_q;
    pkt_cnt_d = pkt_cnt_q;
    cnt_d     = cnt_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
`ifdef AXIS_PACKET_REDUCER_SATURATE_EN
    sat_d     = sat_q;
`endif
    if (state_d == S_ERR) begin
      acc_d     = '0;
      pkt_cnt_d = '0;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
`ifdef AXIS_PACKET_REDUCER_SATURATE_EN
      sat_d     = 1'b0;
`endif
    end else if (start_go) begin
      cnt_d     = packet_count;
      acc_d     = '0;
      pkt_cnt_d = '0;
`ifdef AXIS_PACKET_REDUCER_SATURATE_EN
      sat_d     = 1'b0;
`endif
    end else begin
      if (out_hs) begin
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
      end
      // A tlast beat reloads the output in the same cycle it drains: one result per cycle.
      if (accept && s_axis_tlast) begin
        m_data_d  = sum;
        m_valid_d = 1'b1;
        m_last_d  = (pkt_cnt_q == cnt_q - PCKT_WIDTH'(1));
        acc_d     = '0;
        pkt_cnt_d = pkt_cnt_q + PCKT_WIDTH'(1);
`ifdef AXIS_PACKET_REDUCER_SATURATE_EN
        sat_d     = 1'b0;
`endif
      end else if (accept) begin
        acc_d = sum;
`ifdef AXIS_PACKET_REDUCER_SATURATE_EN
        sat_d = sat_q | ovf;
`endif
      end
    end
    busy_d = (state_d == S_RUN);
    cmpl_d = (state_d == S_DONE) && (state_q != S_DONE);
    err_d  = (state_d == S_ERR) && (state_q != S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      pkt_cnt_q <= '0;
      cnt_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      cmpl_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef AXIS_PACKET_REDUCER_SATURATE_EN
      sat_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      pkt_cnt_q <= pkt_cnt_d;
      cnt_q     <= cnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      cmpl_q    <= cmpl_d;
      err_q     <= err_d;
`ifdef AXIS_PACKET_REDUCER_SATURATE_EN
      sat_q     <= sat_d;
`endif
    end
  end

  assign operation_busy     = busy_q;
  assign operation_complete = cmpl_q;
  assign operation_error    = err_q;
  assign m_axis_tdata       = m_data_q;
  assign m_axis_tvalid      = m_valid_q;
  assign m_axis_tlast       = m_last_q;

endmodule

// File: tb/tb_axis_packet_reducer.sv
// Random and directed stimulus for axis_packet_reducer; a 32-bit and a 16-bit accumulator
// instance share inputs and are checked against an arithmetic packet-sum scoreboard.
module tb_axis_packet_reducer;

  logic        clk = 1'b0;
  logic        rst, start, lock, ext_err;
  logic [31:0] pcount;
  logic [15:0] s_tdata;
  logic        s_tvalid, s_tlast, m_tready;

  logic        busy, cmpl, err, s_tready, m_tvalid, m_tlast;
  logic [31:0] m_tdata;
  logic        busy_o, cmpl_o, err_o, s_tready_o, m_tvalid_o, m_tlast_o;
  logic [15:0] m_tdata_o;

  always #5 clk = ~clk;

  axis_packet_reducer u_dut (
    .clk(clk), .rst(rst), .operation_start(start), .packet_count(pcount), .lock(lock),
    .external_error(ext_err), .operation_busy(busy), .operation_complete(cmpl),
    .operation_error(err), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast));

  axis_packet_reducer #(.DATA_WIDTH(16), .ACC_WIDTH(16)) u_ovf (
    .clk(clk), .rst(rst), .operation_start(start), .packet_count(pcount), .lock(lock),
    .external_error(ext_err), .operation_busy(busy_o), .operation_complete(cmpl_o),
    .operation_error(err_o), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready_o), .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata_o),
    .m_axis_tvalid(m_tvalid_o), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast_o));

  typedef struct {longint d32; longint d16; bit last;} exp_t;
  exp_t   exp_q[$];
  longint hs_t[$];
  int     n_checks = 0, n_errs = 0, n_cmpl = 0, n_err = 0;
  longint cyc = 0;
  longint m32, m16;
  bit     sat32, sat16;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: running signed sum per packet, reduced to the accumulator width.
  function automatic longint madd(input longint a, input longint b, input int w, inout bit sat);
    longint hi, lo, s;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    s  = a + b;
`ifdef AXIS_PACKET_REDUCER_SATURATE_EN
    if (sat) return a;
    if (s > hi) begin sat = 1'b1; return hi; end
    if (s < lo) begin sat = 1'b1; return lo; end
    return s;
`else
    s = s & ((longint'(1) <<< w) - 1);
    if (s > hi) s = s - (longint'(1) <<< w);
    return s;
`endif
  endfunction

  initial forever begin @(posedge clk); cyc++; end

  // Output monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (cmpl) n_cmpl++;
      if (err)  n_err++;
      if (m_tvalid && m_tready) begin
        hs_t.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sum32", longint'($signed(m_tdata)), e.d32);
          check("sum16", longint'($signed(m_tdata_o)), e.d16);
          check("tlast", longint'(m_tlast), longint'(e.last));
          check("ovf_valid", longint'(m_tvalid_o), 1);
        end
      end
      if (m_tvalid && !m_tready) check("stall_ready", longint'(s_tready), 0);
    end
  end

  task automatic start_op(input int n);
    m32 = 0; m16 = 0; sat32 = 1'b0; sat16 = 1'b0;
    start = 1'b1; pcount = 32'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input int d, input bit last, input bit op_last);
    logic ok;
    s_tdata = 16'(d); s_tlast = last; s_tvalid = 1'b1;
    m32 = madd(m32, longint'($signed(s_tdata)), 32, sat32);
    m16 = madd(m16, longint'($signed(s_tdata)), 16, sat16);
    if (last) begin
      exp_q.push_back('{m32, m16, op_last});
      m32 = 0; m16 = 0; sat32 = 1'b0; sat16 = 1'b0;
    end
    for (int n = 0; ; n++) begin
      @(negedge clk); ok = s_tready;
      @(posedge clk); #1;
      if (ok) break;
      if (n > 500) begin check("beat_timeout", 0, 1); break; end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c0;
    c0 = n_cmpl;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (n_cmpl != c0) break;
    end
    check(tag, n_cmpl - c0, 1);
    check({tag, "_busy"}, longint'(busy), 0);
  endtask

  initial begin
    int sz, c0, np, nb;
    bit stop;
    rst = 1'b1; start = 1'b0; pcount = '0; lock = 1'b0; ext_err = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tready", longint'(s_tready), 0);
    check("rst_tvalid", longint'(m_tvalid), 0);
    check("rst_tdata",  longint'(m_tdata), 0);
    check("rst_tlast",  longint'(m_tlast), 0);
    check("rst_busy",   longint'(busy), 0);
    check("rst_flags",  longint'({cmpl, err}), 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Basic sums
    start_op(2);
    check("busy_run", longint'(busy), 1);
    send_beat(1, 0, 0); send_beat(2, 0, 0); send_beat(3, 1, 0);
    send_beat(-4, 0, 0); send_beat(10, 1, 1);
    wait_done("basic_done");

    // Backpressure held for 5 cycles after the first result
    m_tready = 1'b0;
    start_op(2);
    fork
      begin
        send_beat(1, 0, 0); send_beat(2, 0, 0); send_beat(3, 1, 0);
        send_beat(-4, 0, 0); send_beat(10, 1, 1);
      end
      begin
        for (int i = 0; i < 200; i++) begin @(negedge clk); if (m_tvalid) break; end
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("bp_tready", longint'(s_tready), 0);
          check("bp_tvalid", longint'(m_tvalid), 1);
        end
        @(posedge clk); #1; m_tready = 1'b1;
      end
    join
    wait_done("bp_done");

    // Single-beat packets, one result per cycle
    sz = hs_t.size();
    start_op(3);
    send_beat(7, 1, 0); send_beat(-1, 1, 0); send_beat(0, 1, 1);
    wait_done("single_done");
    check("single_cnt", hs_t.size() - sz, 3);
    if (hs_t.size() - sz == 3) begin
      check("b2b_0", hs_t[sz+1] - hs_t[sz], 1);
      check("b2b_1", hs_t[sz+2] - hs_t[sz+1], 1);
    end

    // External error mid-packet, then a fresh operation
    c0 = n_err;
    start_op(2);
    send_beat(5, 0, 0); send_beat(5, 0, 0);
    ext_err = 1'b1;
    @(posedge clk); #1; ext_err = 1'b0;
    @(negedge clk);
    check("err_pulse", longint'(err), 1);
    check("err_tvalid", longint'(m_tvalid), 0);
    check("err_busy", longint'(busy), 0);
    @(posedge clk); #1;
    check("err_count", n_err - c0, 1);
    start_op(1);
    send_beat(3, 1, 1);
    wait_done("after_err_done");

    // Zero packet count
    c0 = n_err;
    sz = hs_t.size();
    start_op(0);
    repeat (4) @(posedge clk); #1;
    check("zero_err", n_err - c0, 1);
    check("zero_noout", hs_t.size() - sz, 0);
    check("zero_busy", longint'(busy), 0);

    // Lock mid-packet
    start_op(1);
    send_beat(2, 0, 0); send_beat(3, 0, 0);
    lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lock_tready", longint'(s_tready), 0);
      check("lock_busy", longint'(busy), 1);
      @(posedge clk); #1;
    end
    lock = 1'b0;
    send_beat(4, 1, 1);
    wait_done("lock_done");

    // Overflow of the 16-bit accumulator
    start_op(1);
    send_beat(32767, 0, 0); send_beat(1, 1, 1);
    wait_done("ovf_done");

    // Randomized operations with random output backpressure
    for (int op = 0; op < 8; op++) begin
      np = int'($urandom_range(1, 4));
      start_op(np);
      stop = 1'b0;
      fork
        begin
          for (int p = 0; p < np; p++) begin
            nb = int'($urandom_range(1, 5));
            for (int b = 0; b < nb; b++)
              send_beat(int'($urandom_range(0, 65535)), b == nb - 1, (b == nb - 1) && (p == np - 1));
          end
          wait_done("rand_done");
          stop = 1'b1;
        end
        begin
          while (!stop) begin
            @(posedge clk); #1;
            m_tready = ($urandom_range(0, 3) != 0);
          end
        end
      join
      m_tready = 1'b1;
      @(posedge clk); #1;
    end

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
